mips_multicycle_control: RTL

Multi-cycle main control FSM for the MIPS datapath. It decodes the 6-bit opcode from the instruction register and sequences each instruction through fetch, decode, execute, memory and writeback steps. It drives every datapath enable and mux select, and produces the 2-bit ALUOp consumed directly by ALUControl: 00 = add, 01 = subtract, 10 = decode funct. Memory accesses stall on a ready handshake so the same FSM works with single-cycle or wait-stated memory.

---
 rtl/mips_multicycle_control.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/mips_multicycle_control.sv
// Multi-cycle main control FSM for the MIPS datapath.
// Sequences each instruction through fetch/decode/execute/memory/writeback,
// stalling on mem_ready in the three memory-access states. Datapath controls
// are decoded from the current state; a few of them are also qualified by
// mem_ready (fetch commit, store completion) or by Op (illegal opcode flag).
module mips_multicycle_control (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] Op,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       MemtoReg,
    output logic       RegDst,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] PCSource,
    output logic       instr_done,
    output logic       illegal_op,
    output logic [3:0] state
);

    // Encodings are visible on the debug port, so they are pinned explicitly.
    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_MEM_WB   = 4'd4,
        S_MEM_WR   = 4'd5,
        S_EXEC     = 4'd6,
        S_ALU_WB   = 4'd7,
        S_BRANCH   = 4'd8,
        S_JUMP     = 4'd9,
        S_IDLE     = 4'd10
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_REG   = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    state_t state_q;
    state_t state_d;
    logic   op_legal;

    // Opcode classification used by DECODE for dispatch and the illegal flag.
    always_comb begin
        op_legal = 1'b0;
        case (Op)
            OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J: op_legal = 1'b1;
            default:                              op_legal = 1'b0;
        endcase
    end

    // Next-state selection; memory states hold until mem_ready completes them.
    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_IDLE:     state_d = S_FETCH;
            S_FETCH:    state_d = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (Op)
                    OP_LW, OP_SW: state_d = S_MEM_ADDR;
                    OP_RTYPE:     state_d = S_EXEC;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
                    default:      state_d = S_FETCH;
                endcase
            end
            // Only lw/sw get here; anything that is not sw is treated as a load.
            S_MEM_ADDR: state_d = (Op == OP_SW) ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD:   state_d = mem_ready ? S_MEM_WB : S_MEM_RD;
            S_MEM_WR:   state_d = mem_ready ? S_FETCH : S_MEM_WR;
            S_MEM_WB:   state_d = S_FETCH;
            S_EXEC:     state_d = S_ALU_WB;
            S_ALU_WB:   state_d = S_FETCH;
            S_BRANCH:   state_d = S_FETCH;
            S_JUMP:     state_d = S_FETCH;
            // Unused encodings recover into FETCH on the next edge.
            default:    state_d = S_FETCH;
        endcase
    end

    // State register; reset parks the FSM in IDLE, abandoning any instruction.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath control decode; every control defaults low, so IDLE and the
    // unused encodings drive nothing.
    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MemtoReg    = 1'b0;
        RegDst      = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = SRCB_REG;
        ALUOp       = ALU_ADD;
        PCSource    = PCSRC_ALU;
        instr_done  = 1'b0;
        illegal_op  = 1'b0;
        case (state_q)
            S_FETCH: begin
                // Keep the read request up through wait states; commit IR
                // and PC+4 only in the cycle the memory delivers.
                MemRead  = 1'b1;
                IorD     = 1'b0;
                ALUSrcA  = 1'b0;
                ALUSrcB  = SRCB_FOUR;
                ALUOp    = ALU_ADD;
                PCSource = PCSRC_ALU;
                IRWrite  = mem_ready;
                PCWrite  = mem_ready;
            end
            S_DECODE: begin
                // Branch target is computed speculatively into ALUOut.
                ALUSrcA    = 1'b0;
                ALUSrcB    = SRCB_IMMSH;
                ALUOp      = ALU_ADD;
                illegal_op = ~op_legal;
            end
            S_MEM_ADDR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
                ALUOp   = ALU_ADD;
            end
            S_MEM_RD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
            end
            S_MEM_WB: begin
                RegWrite   = 1'b1;
                MemtoReg   = 1'b1;
                RegDst     = 1'b0;
                instr_done = 1'b1;
            end
            S_MEM_WR: begin
                // The store only finishes in the cycle memory accepts it.
                MemWrite   = 1'b1;
                IorD       = 1'b1;
                instr_done = mem_ready;
            end
            S_EXEC: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_REG;
                ALUOp   = ALU_FUNCT;
            end
            S_ALU_WB: begin
                RegWrite   = 1'b1;
                RegDst     = 1'b1;
                MemtoReg   = 1'b0;
                instr_done = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUSrcB     = SRCB_REG;
                ALUOp       = ALU_SUB;
                PCWriteCond = 1'b1;
                PCSource    = PCSRC_ALUOUT;
                instr_done  = 1'b1;
            end
            S_JUMP: begin
                PCWrite    = 1'b1;
                PCSource   = PCSRC_JUMP;
                instr_done = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign state = state_q;

endmodule
